// File: rtl/accum_decimate_pkg.sv
// Shared constants and helpers for the block-averaging decimator.
package accum_decimate_pkg;

  localparam int MAX_LOG2_RATIO = 8;

  function automatic int acc_w(input int width, input int log2_ratio);
    return width + log2_ratio;
  endfunction

endpackage

// File: rtl/accum_decimate_ce.sv
// Unsigned block-averaging decimator: sums 2**log2_ratio valid samples,
// emits their floored mean on O with a one-cycle CE strobe per block.
module accum_decimate_ce
  import accum_decimate_pkg::*;
#(
  parameter int width      = 16,
  parameter int log2_ratio = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [width-1:0] I,
  input  logic             VALID,
  input  logic             CLR,
  output logic [width-1:0] O,
  output logic             CE
);

  localparam int ACC_W = acc_w(width, log2_ratio);

  if (log2_ratio < 0 || log2_ratio > MAX_LOG2_RATIO) begin : g_bad_ratio
    $error("accum_decimate_ce: log2_ratio out of range 0..%0d", MAX_LOG2_RATIO);
  end
  if (width < 1) begin : g_bad_width
    $error("accum_decimate_ce: width must be at least 1");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic [width-1:0] o_q, o_d;
  logic             ce_q, ce_d;
  logic             last_sample;

  // The counter wraps naturally from N-1 back to 0, so no explicit clear on completion.
  if (log2_ratio > 0) begin : g_cnt
    logic [log2_ratio-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
        cnt_d = '0;
      end else if (VALID) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign last_sample = &cnt_q;
  end else begin : g_no_cnt
    assign last_sample = 1'b1;
  end

  assign sum = acc_q + ACC_W'(I);

  always_comb begin
    acc_d = acc_q;
    o_d   = o_q;
    ce_d  = 1'b0;
    if (CLR) begin
      acc_d = '0;
    end else if (VALID) begin
      if (last_sample) begin
        acc_d = '0;
        o_d   = width'(sum >> log2_ratio);
        ce_d  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      acc_q <= '0;
      o_q   <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      o_q   <= o_d;
      ce_q  <= ce_d;
    end
  end

  assign O  = o_q;
  assign CE = ce_q;

endmodule

// File: tb/tb_accum_decimate_ce.sv
// Self-checking bench for accum_decimate_ce: ratio-4 and ratio-1 instances
// share stimulus and are compared against a queue-based averaging model.
module tb_accum_decimate_ce;

  logic        CLK = 1'b0;
  logic        ASYNCRESET = 1'b1;
  logic [15:0] I = '0;
  logic        VALID = 1'b0;
  logic        CLR = 1'b0;
  logic [15:0] o2, o0;
  logic        ce2, ce0;

  int errors = 0;
  int checks = 0;

  int unsigned blk2[$];
  logic [15:0] exp_o2 = '0, exp_o0 = '0;
  logic        exp_ce2 = 1'b0, exp_ce0 = 1'b0;

  always #5 CLK = ~CLK;

  accum_decimate_ce #(.width(16), .log2_ratio(2)) dut2 (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .VALID(VALID), .CLR(CLR),
    .O(o2), .CE(ce2)
  );

  accum_decimate_ce #(.width(16), .log2_ratio(0)) dut0 (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .VALID(VALID), .CLR(CLR),
    .O(o0), .CE(ce0)
  );

  task automatic model_reset();
    blk2.delete();
    exp_o2 = '0; exp_ce2 = 1'b0;
    exp_o0 = '0; exp_ce0 = 1'b0;
  endtask

  // One clock of stimulus; afterwards sits 1 time unit past the edge with the model updated.
  task automatic drive(input logic v, input logic [15:0] d, input logic c);
    int unsigned s;
    VALID = v; I = d; CLR = c;
    @(posedge CLK);
    exp_ce2 = 1'b0;
    exp_ce0 = 1'b0;
    if (c) begin
      blk2.delete();
    end else if (v) begin
      blk2.push_back(d);
      if (blk2.size() == 4) begin
        s = 0;
        foreach (blk2[k]) s += blk2[k];
        exp_o2 = 16'(s / 4);
        exp_ce2 = 1'b1;
        blk2.delete();
      end
      exp_o0 = d;
      exp_ce0 = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o2 !== 16'h0) begin errors++; $display("[TB] FAIL reset_o2: got %h want 0000", o2); end
    checks++; if (ce2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce2: got %b want 0", ce2); end
    checks++; if (o0 !== 16'h0) begin errors++; $display("[TB] FAIL reset_o0: got %h want 0000", o0); end
    checks++; if (ce0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce0: got %b want 0", ce0); end
    #1 ASYNCRESET = 1'b0;
    model_reset();
    drive(1'b0, 16'h0, 1'b0);
    checks++; if (ce2 !== 1'b0 || o2 !== 16'h0) begin errors++; $display("[TB] FAIL reset_idle: got ce=%b o=%h want ce=0 o=0000", ce2, o2); end
  endtask

  task automatic test_basic_average();
    logic [15:0] seq [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, seq[k], 1'b0);
      if (k < 3) begin
        checks++; if (ce2 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ce_early%0d: got %b want 0", k, ce2); end
      end
    end
    checks++; if (ce2 !== 1'b1) begin errors++; $display("[TB] FAIL basic_ce: got %b want 1", ce2); end
    checks++; if (o2 !== 16'h0002) begin errors++; $display("[TB] FAIL basic_o: got %h want 0002", o2); end
    drive(1'b0, 16'h0, 1'b0);
    checks++; if (ce2 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ce_after: got %b want 0", ce2); end
    checks++; if (o2 !== 16'h0002) begin errors++; $display("[TB] FAIL basic_o_hold: got %h want 0002", o2); end
  endtask

  task automatic test_full_scale();
    for (int k = 0; k < 4; k++) drive(1'b1, 16'hFFFF, 1'b0);
    checks++; if (ce2 !== 1'b1 || o2 !== 16'hFFFF) begin errors++; $display("[TB] FAIL full_scale: got ce=%b o=%h want ce=1 o=ffff", ce2, o2); end
    for (int k = 0; k < 4; k++) drive(1'b1, (k == 3) ? 16'd1 : 16'd0, 1'b0);
    checks++; if (ce2 !== 1'b1 || o2 !== 16'h0000) begin errors++; $display("[TB] FAIL floor: got ce=%b o=%h want ce=1 o=0000", ce2, o2); end
  endtask

  task automatic test_valid_gaps();
    int pulses = 0;
    logic [15:0] held;
    held = o2;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'd8, 1'b0);
      if (ce2) pulses++;
      if (k < 3) begin
        checks++; if (o2 !== held) begin errors++; $display("[TB] FAIL gaps_hold%0d: got %h want %h", k, o2, held); end
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 16'hDEAD, 1'b0);
          if (ce2) pulses++;
        end
      end
    end
    checks++; if (o2 !== 16'h0008) begin errors++; $display("[TB] FAIL gaps_o: got %h want 0008", o2); end
    drive(1'b0, 16'h0, 1'b0);
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL gaps_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_clr_mid_block();
    int pulses = 0;
    drive(1'b1, 16'd100, 1'b0); if (ce2) pulses++;
    drive(1'b1, 16'd100, 1'b0); if (ce2) pulses++;
    drive(1'b1, 16'd999, 1'b1); if (ce2) pulses++;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'd20, 1'b0);
      if (ce2) pulses++;
    end
    checks++; if (o2 !== 16'd20) begin errors++; $display("[TB] FAIL clr_mid_o: got %0d want 20", o2); end
    drive(1'b0, 16'h0, 1'b0);
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL clr_mid_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_clr_on_last();
    for (int k = 0; k < 3; k++) drive(1'b1, 16'd50, 1'b0);
    drive(1'b1, 16'd50, 1'b1);
    checks++; if (ce2 !== 1'b0) begin errors++; $display("[TB] FAIL clr_last_ce: got %b want 0", ce2); end
    checks++; if (o2 !== 16'd20) begin errors++; $display("[TB] FAIL clr_last_o: got %0d want 20", o2); end
    for (int k = 0; k < 4; k++) drive(1'b1, 16'd5, 1'b0);
    checks++; if (ce2 !== 1'b1 || o2 !== 16'd5) begin errors++; $display("[TB] FAIL clr_last_next: got ce=%b o=%0d want ce=1 o=5", ce2, o2); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 16'd9, 1'b0);
    VALID = 1'b0;
    #2 ASYNCRESET = 1'b1;
    #1;
    model_reset();
    checks++; if (o2 !== 16'h0 || ce2 !== 1'b0) begin errors++; $display("[TB] FAIL arst_dut2: got ce=%b o=%h want ce=0 o=0000", ce2, o2); end
    checks++; if (o0 !== 16'h0 || ce0 !== 1'b0) begin errors++; $display("[TB] FAIL arst_dut0: got ce=%b o=%h want ce=0 o=0000", ce0, o0); end
    #2 ASYNCRESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'd7, 1'b0);
      if (k < 3) begin
        checks++; if (ce2 !== 1'b0) begin errors++; $display("[TB] FAIL arst_ce_early%0d: got %b want 0", k, ce2); end
      end
    end
    checks++; if (ce2 !== 1'b1 || o2 !== 16'd7) begin errors++; $display("[TB] FAIL arst_next: got ce=%b o=%0d want ce=1 o=7", ce2, o2); end
  endtask

  task automatic test_ratio0();
    drive(1'b1, 16'h1234, 1'b0);
    checks++; if (ce0 !== 1'b1 || o0 !== 16'h1234) begin errors++; $display("[TB] FAIL r0_first: got ce=%b o=%h want ce=1 o=1234", ce0, o0); end
    drive(1'b0, 16'h5555, 1'b0);
    checks++; if (ce0 !== 1'b0 || o0 !== 16'h1234) begin errors++; $display("[TB] FAIL r0_idle: got ce=%b o=%h want ce=0 o=1234", ce0, o0); end
    drive(1'b1, 16'hABCD, 1'b0);
    checks++; if (ce0 !== 1'b1 || o0 !== 16'hABCD) begin errors++; $display("[TB] FAIL r0_second: got ce=%b o=%h want ce=1 o=abcd", ce0, o0); end
    drive(1'b1, 16'h0F0F, 1'b0);
    checks++; if (ce0 !== 1'b1 || o0 !== 16'h0F0F) begin errors++; $display("[TB] FAIL r0_b2b: got ce=%b o=%h want ce=1 o=0f0f", ce0, o0); end
  endtask

  task automatic test_random();
    logic        v, c;
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive(v, d, c);
      checks++; if (ce2 !== exp_ce2 || o2 !== exp_o2) begin errors++; $display("[TB] FAIL rand_r4 cyc%0d: got ce=%b o=%h want ce=%b o=%h", n, ce2, o2, exp_ce2, exp_o2); end
      checks++; if (ce0 !== exp_ce0 || o0 !== exp_o0) begin errors++; $display("[TB] FAIL rand_r1 cyc%0d: got ce=%b o=%h want ce=%b o=%h", n, ce0, o0, exp_ce0, exp_o0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_average();
    test_full_scale();
    test_valid_gaps();
    test_clr_mid_block();
    test_clr_on_last();
    test_async_reset();
    test_ratio0();
    drive(1'b0, 16'h0, 1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
